// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: ALU opcodes,
// default datapath sizes and the controller state encoding.
package alu_mul_seq_pkg;

   localparam int MUL_WIDTH = 16;
   localparam int MUL_CNT_W = 5;

   // Opcodes of the shared 16-bit ALU
   localparam logic [2:0] OP_ROL = 3'd0;
   localparam logic [2:0] OP_SLL = 3'd1;
   localparam logic [2:0] OP_ROR = 3'd2;
   localparam logic [2:0] OP_SRA = 3'd3;
   localparam logic [2:0] OP_ADD = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_AND = 3'd7;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADD   = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiplier that borrows the shared ALU for every
// arithmetic step: ADD accumulates the multiplicand into the product, SLL
// doubles the multiplicand. The multiplier register is shifted locally (a
// plain wire shift, not arithmetic). The parent muxes alu_* onto the ALU
// while ready is low.
//
// Handshake: a request is accepted on a rising edge where start && ready.
// ready is high only in IDLE. done pulses for one cycle when product/ofl
// become valid; they then hold until the next accept clears them.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int CNT_W = MUL_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             ofl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic [2:0]       alu_op,
   output logic             alu_invA,
   output logic             alu_invB,
   output logic             alu_sign,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_ofl,
   output logic [1:0]       dbg_state_o
);

   state_e             state_q;
   logic               ready_q;
   logic               done_q;
   logic [WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]   q_q;
   logic [WIDTH-1:0]   acc_q;
   logic               ofl_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   q_shr_d;

   // Multiplier after this step's shift; decides whether more work remains
   assign q_shr_d = q_q >> 1;

   // Controller and datapath registers; outputs are registered alongside state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         m_q     <= '0;
         q_q     <= '0;
         acc_q   <= '0;
         ofl_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start && ready_q) begin
                  m_q     <= mcand;
                  q_q     <= mplier;
                  acc_q   <= '0;
                  ofl_q   <= 1'b0;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  if (mplier == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else if (mplier[0]) begin
                     state_q <= ST_ADD;
                  end else begin
                     state_q <= ST_SHIFT;
                  end
               end
            end
            ST_ADD: begin
               acc_q   <= alu_out;
               ofl_q   <= ofl_q | alu_ofl;
               state_q <= ST_SHIFT;
            end
            ST_SHIFT: begin
               m_q   <= alu_out;
               q_q   <= q_shr_d;
               cnt_q <= cnt_q + CNT_W'(1);
               // A set top bit shifted out matters only if a later add would use it
               if (m_q[WIDTH-1] && (q_shr_d != '0)) begin
                  ofl_q <= 1'b1;
               end
               if ((q_shr_d == '0) || (cnt_q == CNT_W'(WIDTH - 1))) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else if (q_shr_d[0]) begin
                  state_q <= ST_ADD;
               end else begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // ALU drive: operands come straight from state and registers; idle means all zero
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = 3'd0;
      case (state_q)
         ST_ADD: begin
            alu_a  = acc_q;
            alu_b  = m_q;
            alu_op = OP_ADD;
         end
         ST_SHIFT: begin
            alu_a  = m_q;
            alu_b  = WIDTH'(1);
            alu_op = OP_SLL;
         end
         default: begin
            alu_a  = '0;
            alu_b  = '0;
            alu_op = 3'd0;
         end
      endcase
   end

   assign alu_cin     = 1'b0;
   assign alu_invA    = 1'b0;
   assign alu_invB    = 1'b0;
   assign alu_sign    = 1'b0;
   assign ready       = ready_q;
   assign done        = done_q;
   assign product     = acc_q;
   assign ofl         = ofl_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: a behavioural model of the shared ALU sits beside
// the multiplier, directed operand pairs with hand-computed results are
// queued as they are issued, and a monitor checks every done pulse.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start;
  logic [15:0] mcand, mplier;
  logic        ready, done, ofl;
  logic [15:0] product;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_cin, alu_invA, alu_invB, alu_sign, alu_ofl;
  logic [2:0]  alu_op;
  logic [1:0]  dbg_state;

  alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .ready(ready), .done(done), .product(product), .ofl(ofl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .dbg_state_o(dbg_state)
  );

  // ---------------- shared ALU model ----------------
  logic [15:0] a_eff, b_eff;
  logic [16:0] sum;
  logic [31:0] rot_l, rot_r;
  logic [3:0]  amt;
  always_comb begin
    a_eff   = alu_invA ? ~alu_a : alu_a;
    b_eff   = alu_invB ? ~alu_b : alu_b;
    amt     = alu_b[3:0];
    sum     = {1'b0, a_eff} + {1'b0, b_eff} + {16'd0, alu_cin};
    rot_l   = {alu_a, alu_a} << amt;
    rot_r   = {alu_a, alu_a} >> amt;
    alu_out = 16'd0;
    alu_ofl = 1'b0;
    case (alu_op)
      OP_ROL: alu_out = rot_l[31:16];
      OP_SLL: alu_out = alu_a << amt;
      OP_ROR: alu_out = rot_r[15:0];
      OP_SRA: alu_out = $signed(alu_a) >>> amt;
      OP_ADD: begin
        alu_out = sum[15:0];
        alu_ofl = alu_sign ? ((a_eff[15] == b_eff[15]) && (sum[15] != a_eff[15])) : sum[16];
      end
      OP_OR:  alu_out = a_eff | b_eff;
      OP_XOR: alu_out = a_eff ^ b_eff;
      default: alu_out = a_eff & b_eff;
    endcase
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] prod;
    logic        ofl;
    logic [7:0]  lat;
    logic [31:0] acc_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] st_trace[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  exp_t       mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] alu_bus();
    return {9'd0, alu_a | alu_b, alu_op, alu_cin, alu_invA, alu_invB, alu_sign};
  endfunction

  // Monitor: record busy-cycle states, pop and compare on every done pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (!ready) st_trace.push_back(dbg_state);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done with product 0x%0h, want no done", product);
        end else begin
          mon_e = exp_q.pop_front();
          check("product", {16'd0, product}, {16'd0, mon_e.prod});
          check("ofl", {31'd0, ofl}, {31'd0, mon_e.ofl});
          check("latency", cyc - mon_e.acc_cyc, {24'd0, mon_e.lat});
          check("alu_idle_at_done", alu_bus(), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with ready high: present a request for one edge
  task automatic drive_start(input logic [15:0] a, input logic [15:0] b, input logic push,
                             input logic [15:0] ep, input logic eo, input logic [7:0] lat);
    exp_t e;
    check("alu_idle_at_accept", alu_bus(), 32'd0);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    st_trace.delete();
    if (push) begin
      e.prod    = ep;
      e.ofl     = eo;
      e.lat     = lat;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic push,
                       input logic [15:0] ep, input logic eo, input logic [7:0] lat);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0, want ready=1 within 200 cycles");
    end
    drive_start(a, b, push, ep, eo, lat);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, want done within 100 cycles", name);
    end
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int adds;
    logic [1:0] exp_states[6];

    rst = 1'b1; start = 1'b0; mcand = 16'd0; mplier = 16'd0;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_ofl", {31'd0, ofl}, 32'd0);
    check("rst_alu", alu_bus(), 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 3*5: ADD,SHIFT,SHIFT,ADD,SHIFT,DONE
    issue(16'd3, 16'd5, 1'b1, 16'd15, 1'b0, 8'd6);
    wait_done("mul_3x5");
    exp_states = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3};
    check("trace_len_3x5", st_trace.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < st_trace.size()) check("trace_3x5", {30'd0, st_trace[i]}, {30'd0, exp_states[i]});
    end

    // Zero multiplier: straight to DONE, ALU never driven
    issue(16'd1234, 16'd0, 1'b1, 16'd0, 1'b0, 8'd1);
    check("alu_idle_zero_mul", alu_bus(), 32'd0);
    wait_done("mul_zero");

    // Overflow from a shifted-out one, and a full-width result without overflow
    issue(16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b1, 8'd11);
    wait_done("mul_100x100");
    issue(16'h00FF, 16'h0101, 1'b1, 16'hFFFF, 1'b0, 8'd12);
    wait_done("mul_ffx101");

    // Longest operation with a start attempt in the middle
    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 8'd33);
    repeat (5) @(negedge clk);
    check("busy_ready_low", {31'd0, ready}, 32'd0);
    mcand = 16'd3; mplier = 16'd5; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("mul_ffff");
    check("busy_cycles_ffff", st_trace.size(), 32'd33);
    repeat (3) @(negedge clk);
    check("hold_product_ffff", {16'd0, product}, 32'h0001);
    check("hold_ofl_ffff", {31'd0, ofl}, 32'd1);

    // Back-to-back: restart on the first IDLE cycle after done
    issue(16'd7, 16'd9, 1'b1, 16'd63, 1'b0, 8'd7);
    wait_done("mul_7x9");
    @(negedge clk);
    check("ready_after_done", {31'd0, ready}, 32'd1);
    check("held_product_63", {16'd0, product}, 32'd63);
    drive_start(16'd2, 16'd3, 1'b1, 16'd6, 1'b0, 8'd5);
    check("accept_clears_product", {16'd0, product}, 32'd0);
    check("accept_ready_low", {31'd0, ready}, 32'd0);
    wait_done("mul_2x3");

    // Reset in the middle of 100*200, on its second ADD cycle
    issue(16'd100, 16'd200, 1'b0, 16'd0, 1'b0, 8'd0);
    t = 0; adds = 0;
    while (adds < 2 && t < 100) begin
      if (dbg_state == 2'd1) adds++;
      if (adds < 2) @(negedge clk);
      t++;
    end
    check("reached_second_add", {30'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", {16'd0, product}, 32'd0);
    check("abort_ofl", {31'd0, ofl}, 32'd0);
    check("abort_alu", alu_bus(), 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'd4, 16'd4, 1'b1, 16'd16, 1'b0, 8'd5);
    wait_done("mul_4x4");

    // Drain and report
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
